lipsi_loader: RTL and testbench

- Serial program loader upstream of the Lipsi memory_block write port.
- Receives a length-prefixed byte stream on an 8N1 UART line and writes the payload into memory addresses 0..N-1.
- Holds the Lipsi core in reset while loading, then releases it.
- Top-level muxes its wr_en/wr_addr/wr_data onto the memory write port whenever cpu_hold=1.

---
 rtl/lipsi_loader_if.sv | 32 +++
 rtl/lipsi_loader.sv | 211 +++++++++++++++++++++
 tb/tb_lipsi_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lipsi_loader_if.sv
// lipsi_loader_if: groups the loader's serial input, arm strobe, memory
// write port and status lines.
//   master : the loader (drives the write port and status, reads rx/load_req)
//   slave  : the surrounding top level / bench (drives rx/load_req)
//   rx        UART receive line, idle high
//   load_req  one-cycle pulse that arms a new load
//   wr_en/wr_addr/wr_data  memory write port
//   cpu_hold/busy/done/err status, byte_cnt payload bytes written
interface lipsi_loader_if #(
    parameter int ADDR_W = 9
);
    logic              rx;
    logic              load_req;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   byte_cnt;

    modport master (
        input  rx, load_req,
        output wr_en, wr_addr, wr_data, cpu_hold, busy, done, err, byte_cnt
    );

    modport slave (
        output rx, load_req,
        input  wr_en, wr_addr, wr_data, cpu_hold, busy, done, err, byte_cnt
    );
endinterface

// File: rtl/lipsi_loader.sv
// lipsi_loader: serial program loader for the Lipsi memory write port.
// Receives an 8N1 UART stream: length low byte, length high byte, then the
// payload, which is written to addresses 0..len-1. The Lipsi core is held in
// reset (cpu_hold) while loading and released when the load completes.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-low
//   bus    lipsi_loader_if.master (rx, load_req, wr_en, wr_addr, wr_data,
//          cpu_hold, busy, done, err, byte_cnt)
// Optional feature macro: LIPSI_LOADER_CHECKSUM_EN -- expects one trailing
// byte equal to the modulo-256 sum of the payload before signalling done.
module lipsi_loader #(
    parameter int CLK_DIV = 868,
    parameter int ADDR_W  = 9,
    parameter int MAX_LEN = 512
) (
    input  logic           clk,
    input  logic           reset,
    lipsi_loader_if.master bus
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_DIV - 1);
    localparam logic [15:0]      MAX_L16 = 16'(MAX_LEN);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
`ifdef LIPSI_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_DONE, S_ERROR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERROR} state_t;
`endif

    rx_state_t         rstate;
    state_t            state, state_nx;
    logic              rx_s1, rx_s2, rx_prev;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    logic              byte_valid, frame_err;
    logic              busy;
    logic [15:0]       len;
    logic [15:0]       len_nx;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   byte_cnt, cnt_inc;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
`ifdef LIPSI_LOADER_CHECKSUM_EN
    logic [7:0]        sum;
`endif

    assign busy    = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA)
`ifdef LIPSI_LOADER_CHECKSUM_EN
                   || (state == S_CHK)
`endif
                   ;
    assign len_nx  = {shreg, len[7:0]};
    assign cnt_inc = byte_cnt + 1'b1;

    // UART receiver; held in bit-idle whenever no load is in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rstate     <= R_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= bus.rx;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (!busy) begin
                rstate <= R_IDLE;
            end else begin
                case (rstate)
                    R_IDLE: if (rx_prev && !rx_s2) begin
                        rstate <= R_START;
                        cnt    <= HALF_M1;
                    end
                    R_START: if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!rx_s2) begin
                        rstate  <= R_DATA;
                        cnt     <= FULL_M1;
                        bit_idx <= '0;
                    end else begin
                        rstate <= R_IDLE;
                    end
                    R_DATA: if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg   <= {rx_s2, shreg[7:1]};
                        cnt     <= FULL_M1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rstate <= R_STOP;
                    end
                    R_STOP: if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (rx_s2) byte_valid <= 1'b1;
                        else       frame_err  <= 1'b1;
                        rstate <= R_IDLE;
                    end
                    default: rstate <= R_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // DATA leaves on the cycle the last write strobe is out, so wr_en is
    // only ever seen while the state is still DATA.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (bus.load_req) state_nx = S_LEN_LO;
            S_LEN_LO: begin
                if (frame_err)       state_nx = S_ERROR;
                else if (byte_valid) state_nx = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (frame_err) begin
                    state_nx = S_ERROR;
                end else if (byte_valid) begin
                    if (len_nx == 16'd0)
`ifdef LIPSI_LOADER_CHECKSUM_EN
                        state_nx = S_CHK;
`else
                        state_nx = S_DONE;
`endif
                    else if (len_nx > MAX_L16) state_nx = S_ERROR;
                    else                       state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (frame_err) begin
                    state_nx = S_ERROR;
                end else if (wr_en && (16'(cnt_inc) == len)) begin
`ifdef LIPSI_LOADER_CHECKSUM_EN
                    state_nx = S_CHK;
`else
                    state_nx = S_DONE;
`endif
                end
            end
`ifdef LIPSI_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (frame_err)       state_nx = S_ERROR;
                else if (byte_valid) state_nx = (shreg == sum) ? S_DONE : S_ERROR;
            end
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            len      <= '0;
            addr     <= '0;
            byte_cnt <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
`ifdef LIPSI_LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (!busy && bus.load_req) begin
                addr     <= '0;
                byte_cnt <= '0;
`ifdef LIPSI_LOADER_CHECKSUM_EN
                sum      <= '0;
`endif
            end
            if (state == S_LEN_LO && byte_valid) len[7:0]  <= shreg;
            if (state == S_LEN_HI && byte_valid) len[15:8] <= shreg;
            if (state == S_DATA && byte_valid) begin
                wr_en   <= 1'b1;
                wr_addr <= addr;
                wr_data <= shreg;
            end
            if (wr_en) begin
                addr     <= addr + 1'b1;
                byte_cnt <= cnt_inc;
`ifdef LIPSI_LOADER_CHECKSUM_EN
                sum      <= sum + wr_data;
`endif
            end
        end
    end

    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = wr_addr;
    assign bus.wr_data  = wr_data;
    assign bus.busy     = busy;
    assign bus.cpu_hold = busy || (state == S_ERROR);
    assign bus.done     = (state == S_DONE);
    assign bus.err      = (state == S_ERROR);
    assign bus.byte_cnt = byte_cnt;
endmodule

// File: tb/tb_lipsi_loader.sv
// tb_lipsi_loader: directed self-checking bench for lipsi_loader with
// CLK_DIV=4, ADDR_W=9, MAX_LEN=512. Honours LIPSI_LOADER_CHECKSUM_EN.
module tb_lipsi_loader;
    localparam int CLK_DIV = 4;
    localparam int ADDR_W  = 9;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   hold_bad = 0;
    logic prev_done = 1'b0;
    logic prev_hold = 1'b0;
    logic [ADDR_W-1:0] log_addr[$];
    logic [7:0]        log_data[$];
    logic [7:0]        pl[$];
    logic [7:0]        model_sum;

    lipsi_loader_if #(.ADDR_W(ADDR_W)) bus_if ();

    lipsi_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .MAX_LEN(512)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log plus "cpu_hold drops exactly when done rises" watcher.
    always @(negedge clk) begin
        if (bus_if.wr_en) begin
            log_addr.push_back(bus_if.wr_addr);
            log_data.push_back(bus_if.wr_data);
        end
        if (bus_if.done && bus_if.cpu_hold) hold_bad++;
        if (bus_if.done && !prev_done && !prev_hold) hold_bad++;
        prev_done = bus_if.done;
        prev_hold = bus_if.cpu_hold;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus_if.rx = 1'b0;
        repeat (CLK_DIV) tick();
        for (int i = 0; i < 8; i++) begin
            bus_if.rx = b[i];
            repeat (CLK_DIV) tick();
        end
        bus_if.rx = stop_bit;
        repeat (CLK_DIV) tick();
        bus_if.rx = 1'b1;
        repeat (2) tick();
    endtask

    task automatic load_pulse();
        bus_if.load_req = 1'b1;
        tick();
        bus_if.load_req = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic wait_settle();
        int n = 0;
        while (bus_if.busy && n < 200) begin
            tick();
            n++;
        end
        if (bus_if.busy) chk_eq("settle_timeout", 32'(bus_if.busy), 32'd0);
    endtask

    // Length prefix, payload from pl, then (when enabled) sum + adj.
    task automatic send_load(input logic [15:0] len, input logic [7:0] adj);
        model_sum = 8'h00;
        send_byte(len[7:0], 1'b1);
        send_byte(len[15:8], 1'b1);
        foreach (pl[i]) begin
            send_byte(pl[i], 1'b1);
            model_sum = model_sum + pl[i];
        end
`ifdef LIPSI_LOADER_CHECKSUM_EN
        send_byte(model_sum + adj, 1'b1);
`else
        if (adj != 8'h00) $display("note: checksum byte not sent in this build");
`endif
    endtask

    initial begin
        int bad;
        reset           = 1'b0;
        bus_if.rx       = 1'b1;
        bus_if.load_req = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Reset state
        chk_eq("rst_wr_en",    32'(bus_if.wr_en), 0);
        chk_eq("rst_busy",     32'(bus_if.busy), 0);
        chk_eq("rst_done",     32'(bus_if.done), 0);
        chk_eq("rst_err",      32'(bus_if.err), 0);
        chk_eq("rst_cpu_hold", 32'(bus_if.cpu_hold), 0);
        chk_eq("rst_byte_cnt", 32'(bus_if.byte_cnt), 0);
        chk_eq("rst_wr_addr",  32'(bus_if.wr_addr), 0);
        chk_eq("rst_wr_data",  32'(bus_if.wr_data), 0);

        // Frame while idle is ignored
        send_byte(8'h55, 1'b1);
        chk_eq("idle_no_write", log_addr.size(), 0);
        chk_eq("idle_busy", 32'(bus_if.busy), 0);

        // Normal load
        clear_log();
        load_pulse();
        chk_eq("arm_busy", 32'(bus_if.busy), 1);
        chk_eq("arm_hold", 32'(bus_if.cpu_hold), 1);
        pl = '{8'hA1, 8'hB2, 8'hC3};
        send_load(16'd3, 8'h00);
        wait_settle();
        chk_eq("norm_nwr", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            chk_eq("norm_a0", 32'(log_addr[0]), 0); chk_eq("norm_d0", 32'(log_data[0]), 32'hA1);
            chk_eq("norm_a1", 32'(log_addr[1]), 1); chk_eq("norm_d1", 32'(log_data[1]), 32'hB2);
            chk_eq("norm_a2", 32'(log_addr[2]), 2); chk_eq("norm_d2", 32'(log_data[2]), 32'hC3);
        end
        chk_eq("norm_cnt",  32'(bus_if.byte_cnt), 3);
        chk_eq("norm_done", 32'(bus_if.done), 1);
        chk_eq("norm_err",  32'(bus_if.err), 0);
        chk_eq("norm_hold", 32'(bus_if.cpu_hold), 0);

        // len = 0
        clear_log();
        load_pulse();
        chk_eq("len0_clr_done", 32'(bus_if.done), 0);
        pl.delete();
        send_load(16'd0, 8'h00);
        wait_settle();
        chk_eq("len0_done", 32'(bus_if.done), 1);
        chk_eq("len0_nwr", log_addr.size(), 0);

        // len = 512, full address space
        clear_log();
        load_pulse();
        pl.delete();
        for (int i = 0; i < 512; i++) pl.push_back(8'((i * 7 + 3) & 8'hFF));
        send_load(16'h0200, 8'h00);
        wait_settle();
        chk_eq("max_nwr", log_addr.size(), 512);
        bad = 0;
        for (int i = 0; i < 512 && i < log_addr.size(); i++)
            if (log_addr[i] != 9'(i) || log_data[i] != pl[i]) bad++;
        chk_eq("max_content", bad, 0);
        if (log_addr.size() == 512) chk_eq("max_last_addr", 32'(log_addr[511]), 511);
        chk_eq("max_cnt",  32'(bus_if.byte_cnt), 512);
        chk_eq("max_done", 32'(bus_if.done), 1);

        // len = 513 rejected
        clear_log();
        load_pulse();
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        wait_settle();
        chk_eq("over_err",  32'(bus_if.err), 1);
        chk_eq("over_hold", 32'(bus_if.cpu_hold), 1);
        chk_eq("over_nwr",  log_addr.size(), 0);
        chk_eq("over_busy", 32'(bus_if.busy), 0);

        // Framing error on second payload byte
        clear_log();
        load_pulse();
        chk_eq("fr_clr_err", 32'(bus_if.err), 0);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        wait_settle();
        chk_eq("fr_nwr",  log_addr.size(), 1);
        if (log_data.size() > 0) chk_eq("fr_d0", 32'(log_data[0]), 32'h11);
        chk_eq("fr_err",  32'(bus_if.err), 1);
        chk_eq("fr_hold", 32'(bus_if.cpu_hold), 1);

        // Recovery after error
        clear_log();
        load_pulse();
        pl = '{8'h5A};
        send_load(16'd1, 8'h00);
        wait_settle();
        chk_eq("rec_done", 32'(bus_if.done), 1);
        chk_eq("rec_err",  32'(bus_if.err), 0);
        chk_eq("rec_nwr",  log_addr.size(), 1);

        // 1-cycle glitch is not a start bit
        clear_log();
        load_pulse();
        bus_if.rx = 1'b0;
        tick();
        bus_if.rx = 1'b1;
        repeat (60) tick();
        chk_eq("gl_busy", 32'(bus_if.busy), 1);
        pl = '{8'h77};
        send_load(16'd1, 8'h00);
        wait_settle();
        chk_eq("gl_done", 32'(bus_if.done), 1);
        chk_eq("gl_nwr",  log_addr.size(), 1);
        if (log_data.size() > 0) chk_eq("gl_d0", 32'(log_data[0]), 32'h77);

        // Reset in the middle of the second data byte
        clear_log();
        load_pulse();
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h44, 1'b1);
        bus_if.rx = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        tick();
        chk_eq("mr_wr_en", 32'(bus_if.wr_en), 0);
        chk_eq("mr_busy",  32'(bus_if.busy), 0);
        chk_eq("mr_hold",  32'(bus_if.cpu_hold), 0);
        chk_eq("mr_done",  32'(bus_if.done), 0);
        chk_eq("mr_err",   32'(bus_if.err), 0);
        chk_eq("mr_cnt",   32'(bus_if.byte_cnt), 0);
        reset = 1'b1;
        bus_if.rx = 1'b1;
        repeat (50) tick();
        chk_eq("mr_nwr",   log_addr.size(), 1);
        chk_eq("mr_idle",  32'(bus_if.busy), 0);

`ifdef LIPSI_LOADER_CHECKSUM_EN
        clear_log();
        load_pulse();
        pl = '{8'h10, 8'h20};
        send_load(16'd2, 8'h00);
        wait_settle();
        chk_eq("ck_ok_done", 32'(bus_if.done), 1);
        chk_eq("ck_ok_sum",  32'(model_sum), 32'h30);

        clear_log();
        load_pulse();
        send_load(16'd2, 8'h01);
        wait_settle();
        chk_eq("ck_bad_err", 32'(bus_if.err), 1);
        chk_eq("ck_bad_nwr", log_addr.size(), 2);
`endif

        chk_eq("hold_vs_done", hold_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
